// File: rtl/fpu_ss_pkg.sv
// Shared types for the FPU subsystem core-side offload path.
//
// Contents:
//   FPU_XLEN       integer operand width carried in acc_q_req_t
//   acc_prd_req_t  predecode request: instruction word offered to the predecoder
//   acc_prd_rsp_t  predecode response: accept / writeback / mem-op / operand usage
//   issue_state_e  offload issuer FSM states
//   acc_q_req_t    payload of an offload request {instr, rs, wb, mem}
package fpu_ss_pkg;

    localparam int unsigned FPU_XLEN = 32;

    typedef struct packed {
        logic [31:0] q_instr_data;
    } acc_prd_req_t;

    typedef struct packed {
        logic       p_accept;
        logic       p_writeback;
        logic       p_is_mem_op;
        logic [2:0] p_use_rs;     // bit0 = rs1
    } acc_prd_rsp_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRD   = 3'd1,
        OPS   = 3'd2,
        ISSUE = 3'd3,
        ILL   = 3'd4
    } issue_state_e;

    typedef struct packed {
        logic [31:0]           instr;
        logic [3*FPU_XLEN-1:0] rs;   // rs1 in the LSBs
        logic                  wb;
        logic                  mem;
    } acc_q_req_t;

endpackage

// File: rtl/fpu_ss_offload_issuer_wb_tracker.sv
// fpu_ss_wb_tracker: counts offloads that still owe an integer writeback.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   inc           one writeback-producing offload was issued this cycle
//   dec           one writeback completed this cycle
//   count         current number of outstanding writebacks
//   credit_avail  count < MAX_WB_OUTSTANDING
//
// A decrement at count 0 is dropped, so a spurious completion cannot
// underflow. An increment at the maximum is dropped as well; the issuer never
// requests one because it stalls while no credit is available.
// MAX_WB_OUTSTANDING must be at least 1.
module fpu_ss_wb_tracker #(
    parameter int unsigned MAX_WB_OUTSTANDING = 4
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      inc,
    input  logic                                      dec,
    output logic [$clog2(MAX_WB_OUTSTANDING+1)-1:0]   count,
    output logic                                      credit_avail
);

    localparam int unsigned CW = $clog2(MAX_WB_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WB_OUTSTANDING);

    logic dec_eff;

    assign dec_eff      = dec && (count != '0);
    assign credit_avail = (count < MAX_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && !dec_eff) begin
            if (count != MAX_CNT) begin
                count <= count + 1'b1;
            end
        end else if (dec_eff && !inc) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/fpu_ss_offload_issuer.sv
// fpu_ss_offload_issuer: core-side initiator of the accelerator
// predecode/offload interface. One instruction is in flight at a time:
// IDLE -> PRD (predecode) -> OPS (wait operands + writeback credit)
// -> ISSUE (valid/ready offload), or PRD -> ILL (one-cycle illegal pulse).
//
// Optional feature macro: FPU_SS_ISSUE_FLUSH_EN adds flush_i, which abandons
// the in-flight instruction and returns to IDLE.
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   flush_i                   (FPU_SS_ISSUE_FLUSH_EN only) drop in-flight instruction
//   instr_valid_i/ready_o     instruction handshake from core decode
//   instr_data_i              instruction word
//   rs_i, rs_valid_i          integer operands rs1..rs3 (rs1 in LSBs) and valids
//   illegal_o                 one-cycle pulse when predecoder rejects
//   prd_req_o, prd_rsp_i      predecoder request / combinational response
//   acc_q_valid_o/ready_i     offload request handshake
//   acc_q_instr_o, acc_q_rs_o offload payload (unused operands are zero)
//   acc_q_wb_o, acc_q_mem_o   writeback / memory-op flags of the request
//   acc_p_valid_i             one writeback completed
//   wb_pending_o              outstanding writeback count
//   busy_o                    FSM is not IDLE
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. Once acc_q_valid_o rises, it and the payload stay stable
// until that edge.
module fpu_ss_offload_issuer
    import fpu_ss_pkg::*;
#(
    parameter int unsigned MAX_WB_OUTSTANDING = 4,
    // acc_q_req_t carries FPU_XLEN-wide operands; XLEN must match it.
    parameter int unsigned XLEN               = FPU_XLEN
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
`ifdef FPU_SS_ISSUE_FLUSH_EN
    input  logic                                     flush_i,
`endif
    input  logic                                     instr_valid_i,
    output logic                                     instr_ready_o,
    input  logic [31:0]                              instr_data_i,
    input  logic [3*XLEN-1:0]                        rs_i,
    input  logic [2:0]                               rs_valid_i,
    output logic                                     illegal_o,
    output acc_prd_req_t                             prd_req_o,
    input  acc_prd_rsp_t                             prd_rsp_i,
    output logic                                     acc_q_valid_o,
    input  logic                                     acc_q_ready_i,
    output logic [31:0]                              acc_q_instr_o,
    output logic [3*XLEN-1:0]                        acc_q_rs_o,
    output logic                                     acc_q_wb_o,
    output logic                                     acc_q_mem_o,
    input  logic                                     acc_p_valid_i,
    output logic [$clog2(MAX_WB_OUTSTANDING+1)-1:0]  wb_pending_o,
    output logic                                     busy_o
);

    issue_state_e state_q, state_d;

    logic [31:0]       instr_q;
    logic              wb_q;
    logic              mem_q;
    logic [2:0]        use_rs_q;
    acc_q_req_t        req_q;

    logic              credit_avail;
    logic              ops_done;
    logic              issue_hs;
    logic [3*XLEN-1:0] rs_masked;
    logic              flush;

`ifdef FPU_SS_ISSUE_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    // Operands not used by the instruction are forced to zero so the
    // accelerator never sees stale register values.
    always_comb begin
        rs_masked = '0;
        for (int i = 0; i < 3; i++) begin
            if (use_rs_q[i]) begin
                rs_masked[i*XLEN +: XLEN] = rs_i[i*XLEN +: XLEN];
            end
        end
    end

    assign ops_done = ((rs_valid_i & use_rs_q) == use_rs_q) && (!wb_q || credit_avail);
    assign issue_hs = (state_q == ISSUE) && acc_q_ready_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (instr_valid_i) state_d = PRD;
            PRD:     state_d = prd_rsp_i.p_accept ? OPS : ILL;
            OPS:     if (ops_done) state_d = ISSUE;
            ISSUE:   if (acc_q_ready_i) state_d = IDLE;
            ILL:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A flush that coincides with the issue handshake loses to it: the
        // request has already been accepted by the accelerator.
        if (flush && (state_q != IDLE) && !issue_hs) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            instr_q  <= '0;
            wb_q     <= 1'b0;
            mem_q    <= 1'b0;
            use_rs_q <= '0;
            req_q    <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && instr_valid_i) begin
                instr_q <= instr_data_i;
            end
            if (state_q == PRD) begin
                wb_q     <= prd_rsp_i.p_writeback;
                mem_q    <= prd_rsp_i.p_is_mem_op;
                use_rs_q <= prd_rsp_i.p_use_rs;
            end
            // Payload is frozen on OPS exit and held through ISSUE.
            if ((state_q == OPS) && ops_done) begin
                req_q.instr <= instr_q;
                req_q.rs    <= rs_masked;
                req_q.wb    <= wb_q;
                req_q.mem   <= mem_q;
            end
        end
    end

    fpu_ss_wb_tracker #(
        .MAX_WB_OUTSTANDING (MAX_WB_OUTSTANDING)
    ) u_wb_tracker (
        .clk          (clk_i),
        .rst_n        (rst_ni),
        .inc          (issue_hs && req_q.wb),
        .dec          (acc_p_valid_i),
        .count        (wb_pending_o),
        .credit_avail (credit_avail)
    );

    // Ready is masked while reset is asserted so every output reads zero.
    assign instr_ready_o          = rst_ni && (state_q == IDLE);
    assign illegal_o              = (state_q == ILL) && !flush;
    assign prd_req_o.q_instr_data = instr_q;
    assign acc_q_valid_o          = (state_q == ISSUE);
    assign acc_q_instr_o          = req_q.instr;
    assign acc_q_rs_o             = req_q.rs;
    assign acc_q_wb_o             = req_q.wb;
    assign acc_q_mem_o            = req_q.mem;
    assign busy_o                 = (state_q != IDLE);

endmodule

// File: tb/tb_fpu_ss_offload_issuer.sv
// Testbench for fpu_ss_offload_issuer: directed vector table, hand-written
// multi-cycle sequences and a randomized phase against a queue-based model.
module tb_fpu_ss_offload_issuer;
    import fpu_ss_pkg::*;

    localparam int MAX_WB = 4;
    localparam int XL     = 32;
    localparam logic [95:0] RSALL = {32'h33333333, 32'h22222222, 32'h11111111};

    localparam logic [31:0] W_FADD = 32'h00208053;
    localparam logic [31:0] W_BAD  = 32'h00000033;
    localparam logic [31:0] W_FMV  = 32'hF0008053;
    localparam logic [31:0] W_FLE  = 32'hA02080D3;

    // ---------------- clock / reset / signals ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_ni;
    logic          instr_valid;
    logic          instr_ready;
    logic [31:0]   instr_data;
    logic [95:0]   rs;
    logic [2:0]    rs_valid;
    logic          illegal;
    acc_prd_req_t  prd_req;
    acc_prd_rsp_t  prd_rsp;
    logic          acc_q_valid;
    logic          acc_q_ready;
    logic [31:0]   acc_q_instr;
    logic [95:0]   acc_q_rs;
    logic          acc_q_wb;
    logic          acc_q_mem;
    logic          acc_p_valid;
    logic [2:0]    wb_pending;
    logic          busy;
`ifdef FPU_SS_ISSUE_FLUSH_EN
    logic          flush;
`endif

    // manual vs randomized drive of the handshake-side inputs
    logic        rand_en, rand_done;
    logic        ready_man, pv_man, r_ready, r_pv;
    logic [2:0]  rsv_man, r_rsv;
    assign acc_q_ready = rand_en ? r_ready : ready_man;
    assign acc_p_valid = rand_en ? r_pv    : pv_man;
    assign rs_valid    = rand_en ? r_rsv   : rsv_man;

    fpu_ss_offload_issuer #(.MAX_WB_OUTSTANDING(MAX_WB), .XLEN(XL)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
`ifdef FPU_SS_ISSUE_FLUSH_EN
        .flush_i       (flush),
`endif
        .instr_valid_i (instr_valid),
        .instr_ready_o (instr_ready),
        .instr_data_i  (instr_data),
        .rs_i          (rs),
        .rs_valid_i    (rs_valid),
        .illegal_o     (illegal),
        .prd_req_o     (prd_req),
        .prd_rsp_i     (prd_rsp),
        .acc_q_valid_o (acc_q_valid),
        .acc_q_ready_i (acc_q_ready),
        .acc_q_instr_o (acc_q_instr),
        .acc_q_rs_o    (acc_q_rs),
        .acc_q_wb_o    (acc_q_wb),
        .acc_q_mem_o   (acc_q_mem),
        .acc_p_valid_i (acc_p_valid),
        .wb_pending_o  (wb_pending),
        .busy_o        (busy)
    );

    // ---------------- predecoder model ----------------
    function automatic acc_prd_rsp_t prd_model(input logic [31:0] w);
        acc_prd_rsp_t r;
        r = '0;
        case (w)
            W_FADD: r = '{p_accept: 1'b1, p_writeback: 1'b0, p_is_mem_op: 1'b0, p_use_rs: 3'b000};
            W_BAD:  r = '0;
            W_FMV:  r = '{p_accept: 1'b1, p_writeback: 1'b0, p_is_mem_op: 1'b0, p_use_rs: 3'b001};
            W_FLE:  r = '{p_accept: 1'b1, p_writeback: 1'b1, p_is_mem_op: 1'b0, p_use_rs: 3'b000};
            default: begin
                r.p_accept    = (w[6:0] == 7'h53) || (w[6:0] == 7'h07) || (w[6:0] == 7'h27);
                r.p_is_mem_op = r.p_accept && (w[6:0] != 7'h53);
                r.p_writeback = r.p_accept && w[25];
                r.p_use_rs    = r.p_accept ? w[14:12] : 3'b000;
            end
        endcase
        return r;
    endfunction

    always_comb prd_rsp = prd_model(prd_req.q_instr_data);

    function automatic logic [95:0] mask_rs(input logic [95:0] v, input logic [2:0] use_rs);
        logic [95:0] m;
        m = '0;
        for (int i = 0; i < 3; i++) if (use_rs[i]) m[i*32 +: 32] = v[i*32 +: 32];
        return m;
    endfunction

    // ---------------- scoreboard bookkeeping ----------------
    int checks = 0;
    int passed = 0;
    int hs_count = 0;
    int ill_count = 0;
    int model_cnt;
    logic [130:0] exp_q[$];   // {illegal, instr, rs, wb, mem}

    always @(negedge clk) begin
        if (rst_ni && acc_q_valid && acc_q_ready) hs_count++;
        if (rst_ni && illegal) ill_count++;
    end

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] w, input logic [95:0] rv);
        int n;
        n = 0;
        while (!instr_ready && n < 300) begin tick(); n++; end
        if (!instr_ready) begin
            check("offer_wait", instr_ready, 1);
            return;
        end
        instr_valid = 1'b1;
        instr_data  = w;
        rs          = rv;
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!acc_q_valid && n < 50) begin tick(); n++; end
        check(name, acc_q_valid, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin tick(); n++; end
        check("wait_idle", busy, 0);
    endtask

    task automatic pulse_pv();
        pv_man = 1'b1;
        tick();
        pv_man = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] instr;
        logic [95:0] rs;
        logic        ill;
        logic [95:0] exp_rs;
        logic        exp_wb;
        logic        exp_mem;
    } vec_t;
    vec_t vecs[7];

    task automatic run_vec(input vec_t v, input int idx);
        check($sformatf("vec%0d_ready", idx), instr_ready, 1);
        instr_valid = 1'b1;
        instr_data  = v.instr;
        rs          = v.rs;
        tick();                                    // handshake edge ends cycle N
        instr_valid = 1'b0;
        @(negedge clk);                            // N+1
        check($sformatf("vec%0d_prd_req", idx), prd_req.q_instr_data, v.instr);
        check($sformatf("vec%0d_n1_valid", idx), acc_q_valid, 0);
        tick(); @(negedge clk);                    // N+2
        check($sformatf("vec%0d_n2_illegal", idx), illegal, v.ill);
        tick(); @(negedge clk);                    // N+3
        if (v.ill) begin
            check($sformatf("vec%0d_n3_illegal", idx), illegal, 0);
            check($sformatf("vec%0d_n3_valid", idx), acc_q_valid, 0);
            check($sformatf("vec%0d_n3_ready", idx), instr_ready, 1);
        end else begin
            check($sformatf("vec%0d_n3_valid", idx), acc_q_valid, 1);
            check($sformatf("vec%0d_instr", idx), acc_q_instr, v.instr);
            check($sformatf("vec%0d_rs", idx), acc_q_rs, v.exp_rs);
            check($sformatf("vec%0d_wb_mem", idx), {acc_q_wb, acc_q_mem}, {v.exp_wb, v.exp_mem});
            tick(); @(negedge clk);                // N+4
            check($sformatf("vec%0d_n4_ready", idx), instr_ready, 1);
            check($sformatf("vec%0d_n4_valid", idx), acc_q_valid, 0);
        end
        tick();
    endtask

    // ---------------- random-phase monitor ----------------
    task automatic monitor_cycle();
        logic [130:0] e;
        int inc;
        int dec;
        inc = 0;
        check("rand_wb_pending", wb_pending, model_cnt);
        if (acc_q_valid && acc_q_ready) begin
            if (exp_q.size() == 0) check("rand_unexpected_issue", acc_q_valid, 0);
            else begin
                e = exp_q.pop_front();
                check("rand_issue", {1'b0, acc_q_instr, acc_q_rs, acc_q_wb, acc_q_mem}, e);
                inc = e[1] ? 1 : 0;
            end
        end
        if (illegal) begin
            if (exp_q.size() == 0) check("rand_unexpected_illegal", illegal, 0);
            else begin
                e = exp_q.pop_front();
                check("rand_illegal", {1'b1, prd_req.q_instr_data, 98'b0}, e);
            end
        end
        dec = (acc_p_valid && model_cnt > 0) ? 1 : 0;
        model_cnt = model_cnt + inc - dec;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int h0;
        int i0;
        logic [6:0] ops[5];
        ops = '{7'h53, 7'h07, 7'h27, 7'h33, 7'h6F};

        vecs[0] = '{W_FADD, RSALL, 1'b0, 96'h0, 1'b0, 1'b0};
        vecs[1] = '{W_BAD,  RSALL, 1'b1, 96'h0, 1'b0, 1'b0};
        vecs[2] = '{W_FMV, {32'h33333333, 32'h22222222, 32'hDEADBEEF}, 1'b0,
                    {64'h0, 32'hDEADBEEF}, 1'b0, 1'b0};
        vecs[3] = '{32'h02007027, RSALL, 1'b0, RSALL, 1'b1, 1'b1};
        vecs[4] = '{32'h00005007, RSALL, 1'b0, {32'h33333333, 32'h0, 32'h11111111}, 1'b0, 1'b1};
        vecs[5] = '{32'h0000006F, RSALL, 1'b1, 96'h0, 1'b0, 1'b0};
        vecs[6] = '{32'h00003053, RSALL, 1'b0, {32'h0, 32'h22222222, 32'h11111111}, 1'b0, 1'b0};

        rand_en = 0; rand_done = 0;
        ready_man = 1; pv_man = 0; rsv_man = 3'b111;
        r_ready = 0; r_pv = 0; r_rsv = 0;
        instr_valid = 0; instr_data = 0; rs = 0;
`ifdef FPU_SS_ISSUE_FLUSH_EN
        flush = 0;
`endif
        model_cnt = 0;

        // reset state
        rst_ni = 1'b1;
        #1 rst_ni = 1'b0;
        #3;
        check("rst_instr_ready", instr_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", acc_q_valid, 0);
        check("rst_illegal", illegal, 0);
        check("rst_wb_pending", wb_pending, 0);
        check("rst_prd_req", prd_req, 0);
        check("rst_payload", {acc_q_instr, acc_q_rs, acc_q_wb, acc_q_mem}, 0);
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        #1 check("rst_release_ready", instr_ready, 1);
        tick();

        // directed vectors (operands valid, accelerator always ready)
        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);
        check("vec_wb_pending", wb_pending, 1);
        pulse_pv();
        check("vec_wb_retired", wb_pending, 0);

        // FMV.W.X with rs1 arriving late
        rsv_man = 3'b000;
        offer(W_FMV, {32'h33333333, 32'h22222222, 32'hDEADBEEF});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("fmv_wait%0d", i), acc_q_valid, 0);
            tick();
        end
        rsv_man = 3'b001;
        @(negedge clk);
        check("fmv_exit_cycle", acc_q_valid, 0);
        tick(); @(negedge clk);
        check("fmv_valid", acc_q_valid, 1);
        check("fmv_rs", acc_q_rs, {64'h0, 32'hDEADBEEF});
        tick();
        rsv_man = 3'b111;
        wait_idle();

        // backpressure: 7 cycles of ready low
        ready_man = 0;
        offer(W_FADD, RSALL);
        h0 = hs_count;
        wait_valid("bp_valid");
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d", i), {acc_q_valid, acc_q_instr, acc_q_rs, acc_q_wb},
                  {1'b1, W_FADD, 96'h0, 1'b0});
            tick();
        end
        ready_man = 1;
        tick();
        @(negedge clk);
        check("bp_released", acc_q_valid, 0);
        tick();
        check("bp_one_handshake", hs_count, h0 + 1);

        // credit stall at MAX_WB outstanding
        for (int i = 0; i < 4; i++) begin
            offer(W_FLE, RSALL);
            wait_idle();
        end
        check("credit_cnt4", wb_pending, 4);
        offer(W_FLE, RSALL);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("credit_stall%0d", i), {busy, acc_q_valid}, 2'b10);
            tick();
        end
        pulse_pv();
        @(negedge clk);
        check("credit_cnt3", wb_pending, 3);
        check("credit_not_yet", acc_q_valid, 0);
        tick(); @(negedge clk);
        check("credit_issue", acc_q_valid, 1);
        tick(); @(negedge clk);
        check("credit_cnt4_again", wb_pending, 4);
        tick();

        // simultaneous inc/dec, then drain and dec at zero
        pulse_pv();
        check("sim_pre", wb_pending, 3);
        ready_man = 0;
        offer(W_FLE, RSALL);
        wait_valid("sim_valid");
        ready_man = 1; pv_man = 1;
        tick();
        pv_man = 0;
        check("sim_incdec", wb_pending, 3);
        check("sim_idle", busy, 0);
        repeat (3) pulse_pv();
        check("drain_zero", wb_pending, 0);
        pulse_pv();
        check("dec_at_zero", wb_pending, 0);

`ifdef FPU_SS_ISSUE_FLUSH_EN
        // flush while waiting for operands
        h0 = hs_count; i0 = ill_count;
        rsv_man = 3'b000;
        offer(W_FMV, RSALL);
        tick();
        @(negedge clk);
        check("flush_in_ops", {busy, acc_q_valid}, 2'b10);
        tick();
        flush = 1; tick(); flush = 0;
        check("flush_idle", {busy, instr_ready}, 2'b01);
        tick();
        check("flush_no_issue", hs_count, h0);
        check("flush_no_illegal", ill_count, i0);
        rsv_man = 3'b111;
        // flush coinciding with the issue handshake
        ready_man = 0;
        offer(W_FLE, RSALL);
        wait_valid("flush_hs_valid");
        h0 = hs_count;
        ready_man = 1; flush = 1;
        tick();
        flush = 0;
        check("flush_hs_counted", wb_pending, 1);
        check("flush_hs_handshake", hs_count, h0 + 1);
        pulse_pv();
`endif

        // async reset while in ISSUE
        offer(W_FLE, RSALL);
        wait_idle();
        check("rst_mid_pre", wb_pending, 1);
        ready_man = 0;
        offer(W_FADD, RSALL);
        wait_valid("rst_mid_valid");
        i0 = ill_count;
        rst_ni = 1'b0;
        #1;
        check("rst_mid_valid_low", acc_q_valid, 0);
        check("rst_mid_ready_low", instr_ready, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_wb", wb_pending, 0);
        check("rst_mid_payload", {acc_q_instr, acc_q_rs, prd_req}, 0);
        tick();
        rst_ni = 1'b1;
        ready_man = 1;
        tick();
        check("rst_mid_after", {instr_ready, busy, wb_pending}, 5'b10000);
        check("rst_mid_no_illegal", ill_count, i0);

        // randomized phase against the queue model
        model_cnt = 0;
        rand_en = 1;
        fork
            begin
                int n;
                for (int i = 0; i < 40; i++) begin
                    logic [31:0] w;
                    logic [95:0] r;
                    acc_prd_rsp_t p;
                    w = $urandom;
                    w[6:0] = ops[$urandom_range(0, 4)];
                    r = {$urandom, $urandom, $urandom};
                    p = prd_model(w);
                    if (!p.p_accept) exp_q.push_back({1'b1, w, 98'b0});
                    else exp_q.push_back({1'b0, w, mask_rs(r, p.p_use_rs), p.p_writeback, p.p_is_mem_op});
                    offer(w, r);
                end
                n = 0;
                while ((exp_q.size() != 0 || busy) && n < 400) begin tick(); n++; end
                check("rand_drain", exp_q.size(), 0);
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    r_ready = ($urandom_range(0, 9) < 7);
                    r_pv    = ($urandom_range(0, 3) == 0);
                    r_rsv   = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b111;
                end
            end
            begin
                while (!rand_done) begin
                    @(negedge clk);
                    monitor_cycle();
                end
            end
        join
        rand_en = 0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
